// File: rtl/i3c_bus_mode_ctrl.sv
// I3C bus mode controller: tracks OFF/SDR/HDR, latches the HDR mode, and turns
// target reset patterns into peripheral or whole-target reset requests with escalation.
module i3c_bus_mode_ctrl #(
    parameter int unsigned ESC_WINDOW = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       enthdr_i,
    input  logic [2:0] enthdr_mode_i,
    input  logic       rstact_valid_i,
    input  logic [7:0] rstact_i,
    input  logic       hdr_exit_detect_i,
    input  logic       target_reset_detect_i,
    input  logic       periph_rst_ack_i,
    input  logic       target_rst_ack_i,
    output logic       monitor_enable_o,
    output logic       is_in_hdr_mode_o,
    output logic [2:0] hdr_mode_o,
    output logic       hdr_exit_o,
    output logic       periph_rst_req_o,
    output logic       target_rst_req_o
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_SDR      = 2'd1,
        ST_HDR      = 2'd2,
        ST_RST_WAIT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_PERIPH = 2'd1,
        ACT_WHOLE  = 2'd2
    } action_e;

    localparam logic [15:0] ESC_LOAD = 16'(ESC_WINDOW);

    state_e      state_q, state_d;
    action_e     action_q, action_d;
    action_e     resolved_s;
    logic [15:0] esc_q, esc_d;
    logic [2:0]  mode_q, mode_d;
    logic        exit_q, exit_d;
    logic        preq_q, preq_d;
    logic        treq_q, treq_d;
    logic        mon_en_q, hdr_q;
    logic        take_reset_s;

    // Escalation: a default peripheral reset seen again inside the window becomes whole-target.
    always_comb begin
        if ((action_q == ACT_WHOLE) || ((action_q == ACT_PERIPH) && (esc_q != 16'd0))) begin
            resolved_s = ACT_WHOLE;
        end else begin
            resolved_s = action_q;
        end
    end

    // Reset patterns are honoured only in SDR/HDR while enabled.
    always_comb begin
        if (enable_i && target_reset_detect_i &&
            ((state_q == ST_SDR) || (state_q == ST_HDR))) begin
            take_reset_s = 1'b1;
        end else begin
            take_reset_s = 1'b0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        action_d = action_q;
        mode_d   = mode_q;
        exit_d   = 1'b0;
        preq_d   = preq_q;
        treq_d   = treq_q;
        if (esc_q != 16'd0) begin
            esc_d = esc_q - 16'd1;
        end else begin
            esc_d = 16'd0;
        end

        case (state_q)
            ST_OFF: begin
                if (enable_i) begin
                    state_d = ST_SDR;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_SDR: begin
                if (!enable_i) begin
                    state_d = ST_OFF;
                end else if (target_reset_detect_i) begin
                    state_d = ST_SDR;
                end else if (enthdr_i) begin
                    state_d = ST_HDR;
                    mode_d  = enthdr_mode_i;
                end else if (rstact_valid_i) begin
                    case (rstact_i)
                        8'h00: begin
                            action_d = ACT_NONE;
                            esc_d    = 16'd0;
                        end
                        8'h01: begin
                            action_d = ACT_PERIPH;
                            esc_d    = 16'd0;
                        end
                        8'h02: begin
                            action_d = ACT_WHOLE;
                            esc_d    = 16'd0;
                        end
                        default: action_d = action_q;
                    endcase
                end else begin
                    state_d = ST_SDR;
                end
            end
            ST_HDR: begin
                if (!enable_i) begin
                    state_d = ST_OFF;
                end else if (hdr_exit_detect_i) begin
                    state_d = ST_SDR;
                    exit_d  = 1'b1;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_RST_WAIT: begin
                if (preq_q) begin
                    if (periph_rst_ack_i) begin
                        preq_d  = 1'b0;
                        state_d = enable_i ? ST_SDR : ST_OFF;
                    end else begin
                        state_d = ST_RST_WAIT;
                    end
                end else if (treq_q) begin
                    if (target_rst_ack_i) begin
                        treq_d  = 1'b0;
                        state_d = enable_i ? ST_SDR : ST_OFF;
                    end else begin
                        state_d = ST_RST_WAIT;
                    end
                end else begin
                    state_d = enable_i ? ST_SDR : ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Reset handling overrides the per-state transition (HDR exit pulse still stands).
        if (take_reset_s) begin
            action_d = ACT_PERIPH;
            case (resolved_s)
                ACT_PERIPH: begin
                    preq_d  = 1'b1;
                    esc_d   = ESC_LOAD;
                    state_d = ST_RST_WAIT;
                end
                ACT_WHOLE: begin
                    treq_d  = 1'b1;
                    esc_d   = 16'd0;
                    state_d = ST_RST_WAIT;
                end
                default: state_d = ST_SDR;
            endcase
        end else begin
            action_d = action_d;
        end
    end

    // State and registered outputs; status flags derive from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_OFF;
            action_q <= ACT_PERIPH;
            esc_q    <= 16'd0;
            mode_q   <= 3'd0;
            exit_q   <= 1'b0;
            preq_q   <= 1'b0;
            treq_q   <= 1'b0;
            mon_en_q <= 1'b0;
            hdr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            action_q <= action_d;
            esc_q    <= esc_d;
            mode_q   <= mode_d;
            exit_q   <= exit_d;
            preq_q   <= preq_d;
            treq_q   <= treq_d;
            mon_en_q <= (state_d != ST_OFF);
            hdr_q    <= (state_d == ST_HDR);
        end
    end

    assign monitor_enable_o = mon_en_q;
    assign is_in_hdr_mode_o = hdr_q;
    assign hdr_mode_o       = mode_q;
    assign hdr_exit_o       = exit_q;
    assign periph_rst_req_o = preq_q;
    assign target_rst_req_o = treq_q;

endmodule

// File: doc/i3c_bus_mode_ctrl.md
I3C_BUS_MODE_CTRL -- requirements
Module: i3c_bus_mode_ctrl

Interface
REQ-001 Parameter ESC_WINDOW, default 1024, is the escalation window in clk_i cycles (legal 2..65535); the counter is 16 bits.
REQ-002 clk_i  input  1  block clock.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 enable_i  input  1  block enable; 0 forces OFF.
REQ-005 enthdr_i  input  1  single-cycle pulse: ENTHDRx CCC decoded.
REQ-006 enthdr_mode_i  input  3  HDR mode code x, sampled with enthdr_i.
REQ-007 rstact_valid_i  input  1  single-cycle pulse: RSTACT defining byte received.
REQ-008 rstact_i  input  8  RSTACT defining byte.
REQ-009 hdr_exit_detect_i  input  1  HDR exit pattern pulse from bus monitor.
REQ-010 target_reset_detect_i  input  1  target reset pattern pulse from bus monitor.
REQ-011 periph_rst_ack_i / target_rst_ack_i  input  1 each  reset-consumer acknowledges.
REQ-012 monitor_enable_o  output  1  enable to bus monitor.
REQ-013 is_in_hdr_mode_o  output  1  HDR indication to bus monitor and datapath.
REQ-014 hdr_mode_o  output  3  latched HDR mode code.
REQ-015 hdr_exit_o  output  1  single-cycle HDR-exit event.
REQ-016 periph_rst_req_o / target_rst_req_o  output  1 each  level reset requests.

Function
REQ-017 All outputs SHALL be registered; the FSM SHALL have states OFF, SDR, HDR and RST_WAIT.
REQ-018 monitor_enable_o SHALL be 1 iff state != OFF; is_in_hdr_mode_o SHALL be 1 iff state == HDR.
REQ-019 OFF->SDR SHALL occur one cycle after enable_i=1; enable_i=0 SHALL force SDR/HDR->OFF on the next edge, overriding all same-cycle events.
REQ-020 SDR->HDR SHALL occur on enthdr_i, with hdr_mode_o <= enthdr_mode_i; enthdr_i in other states SHALL be ignored.
REQ-021 HDR->SDR SHALL occur on hdr_exit_detect_i, with hdr_exit_o=1 for exactly one cycle after the edge; hdr_exit_detect_i outside HDR SHALL be ignored.
REQ-022 action_q (NONE/PERIPH/WHOLE) SHALL reset to PERIPH; in SDR only, rstact_valid_i SHALL load 0x00->NONE, 0x01->PERIPH, 0x02->WHOLE, and any other byte SHALL be ignored.
REQ-023 Any accepted rstact_valid_i SHALL clear the escalation counter esc_q.
REQ-024 target_reset_detect_i in SDR or HDR SHALL resolve as: WHOLE if action_q=WHOLE, or if action_q=PERIPH and esc_q!=0; otherwise action_q.
REQ-025 On PERIPH: periph_rst_req_o<=1, esc_q<=ESC_WINDOW, state->RST_WAIT.
REQ-026 On WHOLE: target_rst_req_o<=1, esc_q<=0, state->RST_WAIT.
REQ-027 On NONE: no request, state->SDR.
REQ-028 In all three cases action_q SHALL return to PERIPH.
REQ-029 esc_q SHALL decrement by 1 every cycle while nonzero, saturating at 0.
REQ-030 Within RST_WAIT, the active request SHALL hold until its ack_i=1, then deassert on the next edge, and the state SHALL go to SDR (OFF if enable_i=0).
REQ-031 enable_i=0 SHALL NOT abort RST_WAIT, and reset patterns, enthdr_i and rstact_valid_i SHALL be ignored in RST_WAIT.
REQ-032 The two requests SHALL never be high together, and an ack without a pending request SHALL be ignored.
REQ-033 If hdr_exit_detect_i and target_reset_detect_i arrive together in HDR, hdr_exit_o SHALL pulse and the reset SHALL be processed per REQ-024..REQ-028.
REQ-034 If enthdr_i and rstact_valid_i arrive together in SDR, enthdr_i SHALL win and rstact SHALL be dropped.

Reset
REQ-035 While rst_ni=0: state OFF, all outputs 0, hdr_mode_o=0, action_q=PERIPH, esc_q=0; asserting reset in any state, including mid-handshake, SHALL drop requests immediately.

Verification
REQ-036 Enable, enthdr_i with mode 3'd2, then hdr_exit_detect_i -> is_in_hdr_mode_o 1 then 0, hdr_mode_o=2, one hdr_exit_o pulse.
REQ-037 Default action, reset pattern, ack after 5 cycles, second pattern 100 cycles later -> periph_rst_req_o for 6 cycles, then target_rst_req_o (ESC_WINDOW=1024).
REQ-038 Same as REQ-037 with the second pattern at 1100 cycles -> second periph_rst_req_o only.
REQ-039 rstact 0x00 then reset pattern -> no request; next pattern -> periph_rst_req_o; rstact 0x07 -> ignored.
REQ-040 In HDR, exit and reset patterns in the same cycle -> hdr_exit_o pulse plus periph_rst_req_o; enable_i=0 during RST_WAIT -> request holds until ack, then OFF.
REQ-041 rst_ni pulled low while target_rst_req_o=1 -> all outputs 0 asynchronously.
